// File: rtl/coffee_pkg.sv
// Shared types and constants for the coffee vending datapath and dispense controller.
package coffee_pkg;

  localparam int unsigned TYPE_W  = 3;
  localparam int unsigned COIN_W  = 4;
  localparam int unsigned TIMER_W = 24;

  typedef enum logic [TYPE_W-1:0] {
    ESPRESSO    = 3'd0,
    COFFEE_MILK = 3'd1,
    CAPUCCINO   = 3'd2,
    MOCACCINO   = 3'd3
  } coffee_t;

  localparam logic [COIN_W-1:0] PRICE_ESPRESSO    = 4'd3;
  localparam logic [COIN_W-1:0] PRICE_COFFEE_MILK = 4'd4;
  localparam logic [COIN_W-1:0] PRICE_CAPUCCINO   = 4'd5;
  localparam logic [COIN_W-1:0] PRICE_MOCACCINO   = 4'd7;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    BREW = 3'd1,
    PAY  = 3'd2,
    GAP  = 3'd3,
    DONE = 3'd4
  } state_t;

  // Price lookup shared with the subtractor; unknown selections cost nothing.
  function automatic logic [COIN_W-1:0] price_of(input coffee_t sel);
    case (sel)
      ESPRESSO:    price_of = PRICE_ESPRESSO;
      COFFEE_MILK: price_of = PRICE_COFFEE_MILK;
      CAPUCCINO:   price_of = PRICE_CAPUCCINO;
      MOCACCINO:   price_of = PRICE_MOCACCINO;
      default:     price_of = '0;
    endcase
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter with a zero flag; times both the brew phase and the coin gaps.
module cycle_timer
  import coffee_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_value,
  output logic               zero_c
);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - TIMER_W'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/coffee_dispense_ctrl.sv
// Dispense sequencer: accept/reject, timed brew, one coin per pulse change return.
// Optional refund-on-cancel path is built only when CANCEL_REFUND_EN is defined.
module coffee_dispense_ctrl
  import coffee_pkg::*;
#(
  parameter int unsigned BREW_CYCLES = 16,
  parameter int unsigned COIN_GAP    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        cancel,
  input  logic [2:0]  coffee_type,
  input  logic [3:0]  total_coins,
  input  logic        enable,
  input  logic [3:0]  change,
  output logic        busy,
  output logic        brewing,
  output logic        coin_out,
  output logic [3:0]  coins_left,
  output logic [2:0]  active_type,
  output logic        clear_coins,
  output logic        reject,
  output logic        done
);

  state_t              state;
  state_t              state_nx;
  logic                accept_c;
  logic                refund_c;
  logic                tmr_load_c;
  logic [TIMER_W-1:0]  tmr_value_c;
  logic                tmr_zero_c;
  logic [COIN_W-1:0]   coins_left_nx;
  logic [TYPE_W-1:0]   active_type_nx;
  logic                clear_nx;
  logic                reject_nx;
  logic                coin_nx;

  assign accept_c = start && enable;

`ifdef CANCEL_REFUND_EN
  // An accepted start always takes priority over a simultaneous cancel.
  assign refund_c = cancel && !accept_c && (total_coins != '0);
`else
  logic unused_c;
  assign refund_c = 1'b0;
  assign unused_c = ^{cancel, total_coins};
`endif

  cycle_timer u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (tmr_load_c),
    .load_value (tmr_value_c),
    .zero_c     (tmr_zero_c)
  );

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      brewing     <= 1'b0;
      coin_out    <= 1'b0;
      coins_left  <= '0;
      active_type <= '0;
      clear_coins <= 1'b0;
      reject      <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nx;
      busy        <= (state_nx != IDLE);
      brewing     <= (state_nx == BREW);
      coin_out    <= coin_nx;
      coins_left  <= coins_left_nx;
      active_type <= active_type_nx;
      clear_coins <= clear_nx;
      reject      <= reject_nx;
      done        <= (state_nx == DONE);
    end
  end

  // Next state and timer control.
  always_comb begin
    state_nx    = state;
    tmr_load_c  = 1'b0;
    tmr_value_c = '0;
    case (state)
      IDLE: begin
        if (accept_c) begin
          state_nx    = BREW;
          tmr_load_c  = 1'b1;
          tmr_value_c = TIMER_W'(BREW_CYCLES - 1);
        end else if (refund_c) begin
          state_nx = PAY;
        end
      end
      BREW: if (tmr_zero_c) state_nx = PAY;
      PAY: begin
        if (coins_left == '0) begin
          state_nx = DONE;
        end else begin
          state_nx    = GAP;
          tmr_load_c  = 1'b1;
          tmr_value_c = TIMER_W'(COIN_GAP - 1);
        end
      end
      GAP:     if (tmr_zero_c) state_nx = PAY;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Next values of the datapath registers and pulses.
  always_comb begin
    coins_left_nx  = coins_left;
    active_type_nx = active_type;
    clear_nx       = 1'b0;
    reject_nx      = 1'b0;
    case (state)
      IDLE: begin
        reject_nx = start && !enable;
        if (accept_c) begin
          active_type_nx = coffee_type;
          coins_left_nx  = change;
          clear_nx       = 1'b1;
        end else if (refund_c) begin
          coins_left_nx = total_coins;
          clear_nx      = 1'b1;
        end
      end
      PAY:     if (coins_left != '0) coins_left_nx = coins_left - COIN_W'(1);
      DONE:    active_type_nx = '0;
      default: ;
    endcase
    // The coin leaves during the PAY cycle, so the pulse is set on entry.
    coin_nx = (state_nx == PAY) && (coins_left_nx != '0);
  end

endmodule

// File: tb/tb_coffee_dispense_ctrl.sv
// Directed bench for coffee_dispense_ctrl with BREW_CYCLES=4, COIN_GAP=2.
module tb_coffee_dispense_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       cancel;
  logic [2:0] coffee_type;
  logic [3:0] total_coins;
  logic       enable;
  logic [3:0] change;
  logic       busy;
  logic       brewing;
  logic       coin_out;
  logic [3:0] coins_left;
  logic [2:0] active_type;
  logic       clear_coins;
  logic       reject;
  logic       done;

  int n_checks;
  int n_fail;

  logic       cap_busy   [0:63];
  logic       cap_brew   [0:63];
  logic       cap_coin   [0:63];
  logic       cap_clear  [0:63];
  logic       cap_reject [0:63];
  logic       cap_done   [0:63];
  logic [3:0] cap_left   [0:63];
  logic [2:0] cap_type   [0:63];

  logic [12:0] outs;
  assign outs = {busy, brewing, coin_out, coins_left, active_type, clear_coins, reject, done};

  coffee_dispense_ctrl #(.BREW_CYCLES(4), .COIN_GAP(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .cancel      (cancel),
    .coffee_type (coffee_type),
    .total_coins (total_coins),
    .enable      (enable),
    .change      (change),
    .busy        (busy),
    .brewing     (brewing),
    .coin_out    (coin_out),
    .coins_left  (coins_left),
    .active_type (active_type),
    .clear_coins (clear_coins),
    .reject      (reject),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive s0/c0 into edge 0, then record cycles 1..n; smask[i] drives start during cycle i.
  task automatic run_capture(input logic s0, input logic c0, input logic [63:0] smask, input int n);
    start  = s0;
    cancel = c0;
    @(posedge clk); #1;
    start  = 1'b0;
    cancel = 1'b0;
    for (int i = 1; i <= n; i++) begin
      cap_busy[i]   = busy;
      cap_brew[i]   = brewing;
      cap_coin[i]   = coin_out;
      cap_clear[i]  = clear_coins;
      cap_reject[i] = reject;
      cap_done[i]   = done;
      cap_left[i]   = coins_left;
      cap_type[i]   = active_type;
      if (i < n) begin
        start = smask[i];
        @(posedge clk); #1;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_checks++;
    if (outs !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected %b", outs, 13'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (outs !== 13'd0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got %b expected %b", outs, 13'd0);
    end
  endtask

  // Shared by the plain espresso run and the run with stray starts while busy.
  task automatic test_espresso(input logic [63:0] smask, input string tag);
    logic [9:0] got;
    logic [9:0] exp;
    logic [3:0] el;
    coffee_type = 3'd0; total_coins = 4'd5; enable = 1'b1; change = 4'd2;
    run_capture(1'b1, 1'b0, smask, 14);
    for (int i = 1; i <= 14; i++) begin
      el  = (i <= 5) ? 4'd2 : (i <= 8) ? 4'd1 : 4'd0;
      exp = {(i <= 12), (i <= 4), (i == 1), (i == 5 || i == 8), (i == 12), 1'b0, el};
      got = {cap_busy[i], cap_brew[i], cap_clear[i], cap_coin[i], cap_done[i], cap_reject[i], cap_left[i]};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL %s cyc %0d: got %b expected %b (busy,brew,clear,coin,done,reject,left)", tag, i, got, exp);
      end
    end
  endtask

  task automatic test_no_change();
    logic [8:0] got;
    logic [8:0] exp;
    coffee_type = 3'd3; total_coins = 4'd7; enable = 1'b1; change = 4'd0;
    run_capture(1'b1, 1'b0, 64'd0, 8);
    for (int i = 1; i <= 8; i++) begin
      exp = {(i <= 6), (i <= 4), (i == 1), 1'b0, (i == 6), ((i <= 6) ? 3'd3 : 3'd0)};
      got = {cap_busy[i], cap_brew[i], cap_clear[i], cap_coin[i], cap_done[i], cap_type[i]};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL mocaccino cyc %0d: got %b expected %b (busy,brew,clear,coin,done,type)", i, got, exp);
      end
    end
  endtask

  task automatic test_reject();
    logic [2:0] got;
    logic [2:0] exp;
    coffee_type = 3'd2; total_coins = 4'd3; enable = 1'b0; change = 4'hE;
    run_capture(1'b1, 1'b0, 64'd0, 3);
    for (int i = 1; i <= 3; i++) begin
      exp = {(i == 1), 1'b0, 1'b0};
      got = {cap_reject[i], cap_busy[i], cap_clear[i]};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL reject cyc %0d: got %b expected %b (reject,busy,clear)", i, got, exp);
      end
    end
  endtask

  task automatic test_cancel();
    logic [8:0] got;
    logic [8:0] exp;
    int         v;
    int         pulses;
    coffee_type = 3'd0; total_coins = 4'd6; enable = 1'b0; change = 4'd0;
    pulses = 0;
    run_capture(1'b0, 1'b1, 64'd0, 22);
    for (int i = 1; i <= 22; i++) begin
`ifdef CANCEL_REFUND_EN
      v = 6 - (i + 1) / 3;
      if (v < 0) v = 0;
      exp = {(i <= 20), 1'b0, (i == 1), (i <= 16 && (i - 1) % 3 == 0), (i == 20), 4'(v)};
`else
      v = 0;
      exp = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'(v)};
`endif
      got = {cap_busy[i], cap_brew[i], cap_clear[i], cap_coin[i], cap_done[i], cap_left[i]};
      if (cap_coin[i] === 1'b1) pulses++;
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL cancel cyc %0d: got %b expected %b (busy,brew,clear,coin,done,left)", i, got, exp);
      end
    end
    n_checks++;
`ifdef CANCEL_REFUND_EN
    if (pulses != 6) begin
`else
    if (pulses != 0) begin
`endif
      n_fail++;
      $display("FAIL cancel_coin_count: got %0d", pulses);
    end
  endtask

  task automatic test_start_cancel();
    logic [2:0] got;
    logic [2:0] exp;
    // Rejected start plus cancel: reject pulses and the refund (if built) begins.
    coffee_type = 3'd2; total_coins = 4'd6; enable = 1'b0; change = 4'd0;
    run_capture(1'b1, 1'b1, 64'd0, 1);
`ifdef CANCEL_REFUND_EN
    exp = 3'b111;
`else
    exp = 3'b100;
`endif
    got = {cap_reject[1], cap_busy[1], cap_clear[1]};
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL start_cancel_reject: got %b expected %b (reject,busy,clear)", got, exp);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    // Accepted start plus cancel: plain brew, no refund.
    coffee_type = 3'd3; total_coins = 4'd7; enable = 1'b1; change = 4'd0;
    run_capture(1'b1, 1'b1, 64'd0, 8);
    got = {cap_brew[1], cap_coin[1], cap_done[6]};
    n_checks++;
    if (got !== 3'b101 || cap_left[1] !== 4'd0) begin
      n_fail++;
      $display("FAIL start_cancel_accept: got %b left %0d expected 101 left 0 (brew1,coin1,done6)", got, cap_left[1]);
    end
  endtask

  task automatic test_reset_mid();
    logic [8:0] got;
    logic [8:0] exp;
    coffee_type = 3'd0; total_coins = 4'd7; enable = 1'b1; change = 4'd4;
    run_capture(1'b1, 1'b0, 64'd0, 6);
    n_checks++;
    if ({busy, brewing, coin_out, coins_left} !== 7'b1000011) begin
      n_fail++;
      $display("FAIL mid_gap_state: got %b expected %b", {busy, brewing, coin_out, coins_left}, 7'b1000011);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (outs !== 13'd0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got %b expected %b", outs, 13'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    coffee_type = 3'd1; total_coins = 4'd4; enable = 1'b1; change = 4'd0;
    run_capture(1'b1, 1'b0, 64'd0, 8);
    for (int i = 1; i <= 8; i++) begin
      exp = {(i <= 6), (i <= 4), (i == 1), 1'b0, (i == 6), ((i <= 6) ? 3'd1 : 3'd0)};
      got = {cap_busy[i], cap_brew[i], cap_clear[i], cap_coin[i], cap_done[i], cap_type[i]};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL after_reset cyc %0d: got %b expected %b (busy,brew,clear,coin,done,type)", i, got, exp);
      end
    end
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    start       = 1'b0;
    cancel      = 1'b0;
    coffee_type = 3'd0;
    total_coins = 4'd0;
    enable      = 1'b0;
    change      = 4'd0;
    test_reset();
    test_espresso(64'd0, "espresso");
    test_no_change();
    test_reject();
    test_cancel();
    test_start_cancel();
    test_reset_mid();
    test_espresso(64'h0000_0000_0000_0934, "busy_start");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/coffee_dispense_ctrl.md
# coffee_dispense_ctrl

Sequential dispense controller for the coffee vending machine, directly downstream of the price/change subtractor. When the customer confirms a selection and the subtractor reports sufficient credit, it clears the coin accumulator, runs a timed brew phase, then returns the change one coin per pulse. It also refunds the full credit on cancel. It handles reset, busy lockout, and reject signalling.

## Interface
- BREW_CYCLES, 16: length of the brew phase in clock cycles (≥1, ≤2^24)
- COIN_GAP, 4: idle cycles after each coin_out pulse (≥1, ≤255)
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle confirm pulse, synchronous to clk
- cancel  in  1  one-cycle cancel/refund pulse
- coffee_type  in  3  selection (0 espresso, 1 coffee & milk, 2 capuccino, 3 mocaccino)
- total_coins  in  4  current credit from the coin accumulator
- enable  in  1  subtractor: credit sufficient for coffee_type
- change  in  4  subtractor: credit minus price
- busy  out  1  high in every state except IDLE
- brewing  out  1  high only in BREW
- coin_out  out  1  one-cycle pulse per returned coin
- coins_left  out  4  remaining coins to return
- active_type  out  3  latched selection for the display
- clear_coins  out  1  one-cycle pulse telling the accumulator to zero its credit
- reject  out  1  one-cycle pulse: start with insufficient credit
- done  out  1  one-cycle pulse at end of transaction

## Operation
- States: IDLE, BREW, PAY, GAP, DONE.
- IDLE + start + enable: latch coffee_type→active_type and change→coins_left, pulse clear_coins, load the timer with BREW_CYCLES−1, then go to BREW.
- IDLE + start + !enable: pulse reject and stay in IDLE. Any coffee_type > 3 arrives with enable=0, so it is rejected.
- IDLE + cancel + total_coins>0 (no accepted start): latch total_coins→coins_left, pulse clear_coins, go to PAY and skip brewing. Cancel with total_coins=0 is ignored.
- start and cancel in the same cycle: an accepted start wins. Otherwise cancel is processed and reject also pulses.
- BREW: the timer counts down. At 0, go to PAY.
- PAY: if coins_left=0, go to DONE. Otherwise pulse coin_out, decrement coins_left, load the timer with COIN_GAP−1, and go to GAP.
- GAP: the timer counts down. At 0, go to PAY.
- DONE: pulse done, clear active_type, go to IDLE.
- start and cancel are ignored while busy.
- Arithmetic is unsigned. coins_left never decrements below 0.

## Timing
- All outputs are registered.
- Reset values: every output is 0, state is IDLE, the timer is 0.
- Reset asserted mid-transaction aborts immediately. Unreturned change is lost and no done pulse is produced.
- Request sampled at edge N: clear_coins, busy and brewing (or reject) are high in cycle N+1.
- Brew occupies exactly BREW_CYCLES cycles.
- Each coin takes 1+COIN_GAP cycles. coin_out pulses are spaced 1+COIN_GAP apart.
- done is high in the cycle after the final PAY cycle. busy falls in the same cycle done falls.
- Total transaction length is 1 + BREW_CYCLES + change·(1+COIN_GAP) + 2 cycles. A refund transaction has no BREW term.

## Configuration
- CANCEL_REFUND_EN defined: cancel behaves as above.
- CANCEL_REFUND_EN undefined: the cancel port remains but is ignored, and the refund path is not synthesized. start+cancel then behaves as start alone.

## Structure
- Shared package coffee_pkg holds:
  - the coffee_type enum (ESPRESSO=0, COFFEE_MILK=1, CAPUCCINO=2, MOCACCINO=3)
  - price constants 3/4/5/7, shared with the subtractor
  - the state enum
- One sub-module, cycle_timer: a loadable down-counter with a zero flag, used for both BREW and GAP.

## Test plan
- Espresso, credit 5 (enable=1, change=2), BREW_CYCLES=4, COIN_GAP=2, start at cycle 0:
  - clear_coins at cycle 1
  - brewing high in cycles 1–4
  - coin_out at cycles 5 and 8
  - done at cycle 12
  - idle at cycle 13
- Mocaccino, credit 7 (change=0): no coin_out pulses. done 1+4+2 cycles after start.
- Capuccino, credit 3 (enable=0), start: reject pulses for 1 cycle, busy stays 0, clear_coins stays 0.
- Cancel with total_coins=6 in IDLE:
  - brewing never asserts
  - exactly 6 coin_out pulses, coins_left counting 6→0
  - done pulses
  - repeat with the macro undefined: no response
- rst_n asserted during GAP with coins_left=3: all outputs 0 immediately. After release, a new start with coffee_type=1 and credit 4 completes normally.
- start pulsed repeatedly during BREW and PAY: no effect, and the transaction timing is unchanged.
